leaf_gpu_ingress_queue: RTL
===========================

// Module: leaf_gpu_ingress_queue
// PURPOSE
//  GPU-side injection stage directly upstream of the leaf router's GPU input port (gpu_in_*).
//  Buffers GPU flits and their 6-bit destination addresses in a FIFO.
//  Drops self-addressed flits and presents one flit at a time to the router through a registered valid/ready output.
//  Supplies the real FIFO status that the router currently ties off.
// PARAMETERS
//  DWIDTH      16       flit data width
//  FIFO_DEPTH  8        queue entries; power of 2, >=2
//  GROUP_ID    4'b0111  this leaf's group; dest_addr[5:2]
//  ROUTER_ID   2        this leaf's index; dest_addr[1:0]
// PORTS
//  clk            in   1               rising-edge clock
//  reset          in   1               async, active-high; clears all state
//  arb_enable     in   1               router arbitration enable; 0 = stop issuing new flits
//  gpu_in_data    in   DWIDTH          flit from GPU
//  gpu_in_valid   in   1               GPU flit valid
//  gpu_dest_addr  in   6               {group[3:0], router[1:0]}
//  gpu_in_ready   out  1               queue can accept this cycle (= !fifo_full)
//  rtr_out_data   out  DWIDTH          flit to router gpu_in_data
//  rtr_out_valid  out  1               flit to router is valid
//  rtr_dest_addr  out  6               address to router gpu_dest_addr
//  rtr_ready      in   1               router accepts the flit (tie 1 if no backpressure)
//  fifo_full      out  1               FIFO holds FIFO_DEPTH entries
//  fifo_empty     out  1               FIFO holds 0 entries (output register excluded)
//  fifo_count     out  $clog2(D)+1     FIFO occupancy
//  drop_count     out  8               self-addressed drops; saturates at 255
//  flit_count     out  16              flits delivered to router; wraps at 2^16
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except fifo_empty=1 and gpu_in_ready=1.
//   - FSM enters S_IDLE; FIFO pointers cleared.
//   - Reset asserted mid-operation discards all queued and presented flits immediately.
//  Ingress
//   - Accept when gpu_in_valid && gpu_in_ready.
//   - gpu_in_ready = !fifo_full, with no bypass: a read in the same cycle does not free space.
//   - An accepted flit with dest == {GROUP_ID, ROUTER_ID[1:0]} is consumed but not enqueued; drop_count += 1, saturating.
//  FIFO
//   - Entry = {dest[5:0], data}; write/read pointers wrap modulo FIFO_DEPTH.
//   - Simultaneous write and read leaves fifo_count unchanged.
//  Output FSM
//   - S_IDLE: rtr_out_valid=0. Go to S_VALID and load the output register from the FIFO head when arb_enable && !fifo_empty.
//   - S_VALID: rtr_out_valid=1; data/dest are held stable until rtr_ready.
//     - On the handshake (rtr_ready=1), flit_count += 1.
//     - If arb_enable && !fifo_empty, reload from the head and stay in S_VALID (1 flit/cycle).
//     - Otherwise go to S_IDLE.
//   - arb_enable=0 never retracts a presented flit; it only blocks new loads.
//  Latency
//   - A flit written at edge t into an empty queue with arb_enable=1 shows rtr_out_valid=1 after edge t+1.
//   - Sustained throughput is 1 flit/clk.
//  Ordering
//   - Strict FIFO; no reordering or duplication.
//   - A flit is never lost except by a self-address drop or by reset.
// STRUCTURE
//  - Shared include leaf_noc_defs.vh holds: ADDR_W=6, GROUP_W=4, the S_IDLE/S_VALID state encodings, and a local-address compare macro.
//  - One sub-module: leaf_sync_fifo (parameters DWIDTH+6, DEPTH; outputs full/empty/count).
//  - The output register and FSM stay in this module.
// TESTING
//  1. Reset, then write 3 flits (0x1111/0x2222/0x3333, dest 6'h1D) with rtr_ready=1, arb_enable=1.
//     -> Same order, first valid 2 clks after the first write, back-to-back; flit_count=3.
//  2. rtr_ready=0, write 9 flits.
//     -> 1 held in the output register, 8 in the FIFO.
//     -> fifo_full=1, gpu_in_ready=0; the 10th flit is not accepted; rtr_out_data stable.
//     -> Release rtr_ready: 9 flits delivered in order.
//  3. Write dest 6'h1E (={7,2}) x300.
//     -> Nothing enqueued; fifo_empty stays 1; drop_count=255 (saturated).
//  4. Fill 4 flits, drop arb_enable for 5 clks while rtr_ready=1.
//     -> The presented flit completes; no new valid until arb_enable=1; no loss.
//  5. Assert reset with 5 flits queued and 1 presented.
//     -> Next cycle: rtr_out_valid=0, fifo_count=0, counters=0; FIFO ordering restarts cleanly.
//  6. Full FIFO, read and write the same cycle.
//     -> Write refused (gpu_in_ready=0); fifo_count goes to 7.

Source files
------------

// File: rtl/leaf_gpu_ingress_queue_pkg.sv
// Shared definitions for the leaf GPU ingress queue: address field widths,
// output FSM state encoding and the local-address compare.
package leaf_gpu_ingress_queue_pkg;

  localparam int ADDR_W   = 6;
  localparam int GROUP_W  = 4;
  localparam int ROUTER_W = ADDR_W - GROUP_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  // True when a destination address names this leaf itself.
  function automatic logic is_local_addr(
    input logic [ADDR_W-1:0]   addr,
    input logic [GROUP_W-1:0]  group_id,
    input logic [ROUTER_W-1:0] router_id
  );
    return addr == {group_id, router_id};
  endfunction

endpackage

// File: rtl/leaf_gpu_ingress_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible combinationally
// on rd_data whenever the FIFO is not empty.
module leaf_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Full blocks writes even when a read frees a slot in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_gpu_ingress_queue.sv
// GPU injection stage ahead of the leaf router: queues flits, drops
// self-addressed ones and presents one flit at a time on a registered output.
module leaf_gpu_ingress_queue
  import leaf_gpu_ingress_queue_pkg::*;
#(
  parameter int                 DWIDTH     = 16,
  parameter int                 FIFO_DEPTH = 8,
  parameter logic [GROUP_W-1:0] GROUP_ID   = 4'b0111,
  parameter int                 ROUTER_ID  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arb_enable,
  input  logic [DWIDTH-1:0]           gpu_in_data,
  input  logic                        gpu_in_valid,
  input  logic [ADDR_W-1:0]           gpu_dest_addr,
  output logic                        gpu_in_ready,
  output logic [DWIDTH-1:0]           rtr_out_data,
  output logic                        rtr_out_valid,
  output logic [ADDR_W-1:0]           rtr_dest_addr,
  input  logic                        rtr_ready,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_count,
  output logic [15:0]                 flit_count
);

  localparam int                  ENTRY_W     = DWIDTH + ADDR_W;
  localparam logic [ROUTER_W-1:0] ROUTER_BITS = ROUTER_W'(ROUTER_ID);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic               accept_p0;
  logic               local_p0;
  logic               wr_en_p0;
  logic               drop_p0;
  logic [ENTRY_W-1:0] head_p0;
  logic               load_p0;
  state_t             state;
  state_t             state_nxt;
  logic               vld_p1;
  logic [DWIDTH-1:0]  out_data_p1;
  logic [ADDR_W-1:0]  out_dest_p1;

  // Stage p0: ingress accept, self-address filter, FIFO
  assign gpu_in_ready = !fifo_full;
  assign accept_p0    = gpu_in_valid && gpu_in_ready;
  assign local_p0     = is_local_addr(gpu_dest_addr, GROUP_ID, ROUTER_BITS);
  assign wr_en_p0     = accept_p0 && !local_p0;
  assign drop_p0      = accept_p0 && local_p0;

  leaf_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_p0),
    .wr_data ({gpu_dest_addr, gpu_in_data}),
    .rd_en   (load_p0),
    .rd_data (head_p0),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A presented flit is never withdrawn; arb_enable only gates the next load.
  always_comb begin
    state_nxt = state;
    load_p0   = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_enable && !fifo_empty) begin
          load_p0   = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (rtr_ready) begin
          if (arb_enable && !fifo_empty) begin
            load_p0 = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: output register toward the router
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      out_data_p1 <= '0;
      out_dest_p1 <= '0;
      drop_count  <= '0;
      flit_count  <= '0;
    end else begin
      state <= state_nxt;
      if (load_p0) begin
        out_data_p1 <= head_p0[DWIDTH-1:0];
        out_dest_p1 <= head_p0[ENTRY_W-1:DWIDTH];
      end
      if (vld_p1 && rtr_ready) begin
        flit_count <= flit_count + 16'd1;
      end
      if (drop_p0) begin
        drop_count <= sat_inc8(drop_count);
      end
    end
  end

  assign vld_p1        = (state == S_VALID);
  assign rtr_out_valid = vld_p1;
  assign rtr_out_data  = out_data_p1;
  assign rtr_dest_addr = out_dest_p1;

endmodule
